// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSFER = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_NUM_REQ        = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  // Index width that stays legal (>= 1 bit) even for a single entry.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin picker: first set request after last_owner, wrapping.
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic               pick_valid
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output gets a default before the loop so no path leaves a latch.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(last_owner) + k) % NUM_REQ);
      if (!pick_valid && req[idx]) begin
        pick[idx]  = 1'b1;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ message sources, one whole message at a time.
// Optional stall timeout on an open grant: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    buffer_full,
  output logic                    tx_write_enable,
  output logic [7:0]              tx_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_error
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("uart_tx_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic               tx_we_q, tx_we_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               accept;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = idx_width(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_owner (last_owner_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tx_we_d      = 1'b0;
    tx_data_d    = tx_data_q;
    req_ready    = '0;
    accept       = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    stall_d      = stall_q;
    timeout_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = TRANSFER;
          grant_d = pick;
          owner_d = pick_idx;
`ifdef UART_TX_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      TRANSFER: begin
        // Only the owner ever sees ready; other requesters are invisible until release.
        req_ready[owner_q] = !buffer_full;
        accept             = req_valid[owner_q] && !buffer_full;
        if (accept) begin
          tx_we_d   = 1'b1;
          tx_data_d = req_data[owner_q];
`ifdef UART_TX_ARB_TIMEOUT_EN
          stall_d   = '0;
`endif
          if (req_last[owner_q]) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (!req_valid[owner_q]) begin
          if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
            timeout_d    = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      tx_we_q      <= 1'b0;
      tx_data_q    <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_q      <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tx_we_q      <= tx_we_d;
      tx_data_q    <= tx_data_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_q      <= stall_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign grant           = grant_q;
  assign busy            = (state_q == TRANSFER);
  assign tx_write_enable = tx_we_q;
  assign tx_data         = tx_data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_error   = timeout_q;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: stall limit for an open grant; used only with UART_TX_ARB_TIMEOUT_EN.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-requester byte valid.
REQ-006 req_data  in  NUM_REQ x 8  per-requester byte.
REQ-007 req_last  in  NUM_REQ  marks the final byte of a message.
REQ-008 req_ready  out  NUM_REQ  per-requester byte accept.
REQ-009 buffer_full  in  1  transmitter buffer-full flag.
REQ-010 tx_write_enable  out  1  write strobe to the transmitter.
REQ-011 tx_data  out  8  byte to the transmitter.
REQ-012 grant  out  NUM_REQ  one-hot current owner; all zero when idle.
REQ-013 busy  out  1  high while a message is in progress.
REQ-014 timeout_error  out  1  one-cycle pulse on a forced grant release; present only with UART_TX_ARB_TIMEOUT_EN.

Function
REQ-015 The FSM SHALL have two states: IDLE and TRANSFER.
REQ-016 In IDLE with any req_valid high, the arbiter SHALL select the first valid requester, searching round-robin from (last_owner+1) mod NUM_REQ.
REQ-017 The selected requester SHALL drive grant on the next edge, and the FSM SHALL enter TRANSFER with busy=1.
REQ-018 In TRANSFER, req_ready[owner] SHALL equal !buffer_full; every other req_ready bit SHALL be 0; in IDLE all req_ready SHALL be 0.
REQ-019 A byte SHALL be accepted when req_valid[owner] && req_ready[owner] are both high.
REQ-020 tx_write_enable SHALL pulse high, and tx_data SHALL hold the accepted byte, exactly one cycle after acceptance; both are registered outputs.
REQ-021 tx_write_enable SHALL be low in all other cycles; tx_data SHALL hold its last value.
REQ-022 Accepting a byte with req_last=1 SHALL return the FSM to IDLE on that edge, clear grant and busy, and store the owner as last_owner.
REQ-023 Back-to-back messages SHALL incur exactly one IDLE bubble cycle between a last-byte acceptance and the next grant.
REQ-024 If the owner deasserts req_valid mid-message, the grant SHALL be held and other requesters SHALL NOT be served.
REQ-025 The downstream transmitter threshold SHALL be programmed at or below depth-1; this absorbs the one in-flight write not yet reflected in buffer_full.
REQ-026 Changes on req_valid or req_data of non-owners SHALL have no effect during TRANSFER.

Reset
REQ-027 Reset assertion SHALL act immediately at any point, including mid-message.
REQ-028 Reset values: FSM=IDLE, grant=0, busy=0, req_ready=0, tx_write_enable=0, tx_data=0, timeout_error=0.
REQ-029 Reset SHALL set last_owner=NUM_REQ-1, so requester 0 has first priority after reset.
REQ-030 A message interrupted by reset SHALL be abandoned; no completion SHALL be signalled.

Configuration
REQ-031 With UART_TX_ARB_TIMEOUT_EN defined, a stall counter SHALL count TRANSFER cycles in which req_valid[owner]=0; it SHALL clear on any acceptance and on grant.
REQ-032 When the stall counter reaches TIMEOUT_CYCLES, the arbiter SHALL return to IDLE, update last_owner, and pulse timeout_error for one cycle.
REQ-033 Without UART_TX_ARB_TIMEOUT_EN, the port timeout_error and the counter SHALL NOT exist, and grants SHALL be held indefinitely.

Structure
REQ-034 Package uart_tx_arbiter_pkg SHALL hold the state enum (IDLE, TRANSFER), the default NUM_REQ, and the default TIMEOUT_CYCLES.
REQ-035 Round-robin selection SHALL be a combinational sub-module, rr_priority_picker (inputs: request vector and last_owner; output: one-hot pick plus a valid flag).

Verification
REQ-036 Scenario 1: after reset, req_valid=4'b1111, each requester sends one byte with last=1 -> grant order 0,1,2,3, with tx_data matching each byte one cycle after its acceptance.
REQ-037 Scenario 2: requester 2 sends 0x41,0x42,0x43 (last on 0x43) while requester 1 is valid -> all three bytes are written before grant moves to requester 1.
REQ-038 Scenario 3: buffer_full=1 for 10 cycles during a message -> req_ready=0 and tx_write_enable=0 for those cycles, no bytes lost, and transfer resumes the cycle after buffer_full falls.
REQ-039 Scenario 4: reset pulsed after the 2nd of 4 bytes -> all outputs at reset values immediately, and the next grant goes to requester 0.
REQ-040 Scenario 5 (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): owner 1 drops req_valid mid-message -> timeout_error pulses 8 cycles later and requester 2 (valid) is granted after one IDLE cycle.
